// File: rtl/axi_sched_pkg.sv
// Shared types and width helpers for the AXI write-path scheduler.
// Optional QoS arbitration is enabled by defining AXI_WR_SCHED_QOS_EN.
package axi_sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int issue);
    return $clog2(issue + 1);
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin pick from a pointer and request vector.
// With AXI_WR_SCHED_QOS_EN, only requesters at the top QoS level compete.
module axi_rr_arbiter
  import axi_sched_pkg::*;
#(
  parameter int  S_COUNT = 4,
  localparam int SEL_W   = sel_w(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req_i,
  input  logic [SEL_W-1:0]     ptr_i,
`ifdef AXI_WR_SCHED_QOS_EN
  input  logic [S_COUNT*4-1:0] qos_i,
`endif
  output logic                 gnt_any_o,
  output logic [SEL_W-1:0]     gnt_idx_o
);

  logic [S_COUNT-1:0] elig;

`ifdef AXI_WR_SCHED_QOS_EN
  logic [3:0] qmax;

  // Mask requesters down to those sharing the highest QoS
  always_comb begin
    qmax = '0;
    elig = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (req_i[i] && (qos_i[i*4 +: 4] > qmax)) begin
        qmax = qos_i[i*4 +: 4];
      end
    end
    for (int i = 0; i < S_COUNT; i++) begin
      elig[i] = req_i[i] && (qos_i[i*4 +: 4] == qmax);
    end
  end
`else
  assign elig = req_i;
`endif

  // First eligible index at or after the pointer, wrapping
  always_comb begin
    logic found;
    int   j;
    found     = 1'b0;
    j         = 0;
    gnt_idx_o = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      j = (int'(ptr_i) + i) % S_COUNT;
      if (!found && elig[j]) begin
        found     = 1'b1;
        gnt_idx_o = SEL_W'(j);
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/axi_wr_sched.sv
// AW arbiter + in-order W select FIFO + outstanding-write limiter.
// Define AXI_WR_SCHED_QOS_EN to add s_awqos and QoS-first arbitration.
module axi_wr_sched
  import axi_sched_pkg::*;
#(
  parameter int  S_COUNT = 4,
  parameter int  ISSUE   = 4,
  parameter int  W_DEPTH = 4,
  localparam int SEL_W   = sel_w(S_COUNT),
  localparam int CNT_W   = cnt_w(ISSUE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_COUNT-1:0]   s_awvalid,
`ifdef AXI_WR_SCHED_QOS_EN
  input  logic [S_COUNT*4-1:0] s_awqos,
`endif
  output logic [S_COUNT-1:0]   s_awready,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [SEL_W-1:0]     aw_sel,
  output logic [SEL_W-1:0]     w_sel,
  output logic                 w_sel_valid,
  input  logic                 w_last_hs,
  input  logic                 b_hs,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err
);

  localparam int PW = $clog2(W_DEPTH);
  localparam logic [CNT_W-1:0] ISSUE_C = CNT_W'(ISSUE);
  localparam logic [SEL_W-1:0] LAST_C  = SEL_W'(S_COUNT - 1);

  sched_state_e     state_q, state_d;
  logic [SEL_W-1:0] aw_sel_q, aw_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [SEL_W-1:0] fifo_q [W_DEPTH];

  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             full, empty;
  logic             grant, aw_hs, pop, b_dec, drop;

  axi_rr_arbiter #(
    .S_COUNT (S_COUNT)
  ) u_arb (
    .req_i     (s_awvalid),
    .ptr_i     (ptr_q),
`ifdef AXI_WR_SCHED_QOS_EN
    .qos_i     (s_awqos),
`endif
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign grant = (state_q == ARB) && gnt_any &&
                 !full && (out_q < ISSUE_C);
  assign aw_hs = (state_q == HOLD) && m_awready;
  assign pop   = w_last_hs && !empty;
  assign b_dec = b_hs && (out_q != '0);
  assign drop  = (state_q == HOLD) && !s_awvalid[aw_sel_q];

  assign m_awvalid   = (state_q == HOLD);
  assign aw_sel      = aw_sel_q;
  assign w_sel_valid = !empty;
  assign w_sel       = empty ? '0 : fifo_q[rd_q[PW-1:0]];
  assign outstanding = out_q;
  assign err         = err_q;

  // AW FSM: grant in ARB, hold address stable until downstream accepts
  always_comb begin
    state_d   = state_q;
    aw_sel_d  = aw_sel_q;
    ptr_d     = ptr_q;
    s_awready = '0;
    unique case (state_q)
      ARB: begin
        if (grant) begin
          aw_sel_d = gnt_idx;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        s_awready[aw_sel_q] = m_awready;
        if (m_awready) begin
          ptr_d   = (aw_sel_q == LAST_C) ? '0 : aw_sel_q + 1'b1;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FIFO pointers, outstanding count and sticky error next-state
  always_comb begin
    wr_d  = aw_hs ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    out_d = out_q;
    unique case ({aw_hs, b_dec})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    err_d = err_q | drop |
            (w_last_hs && empty) |
            (b_hs && (out_q == '0));
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      aw_sel_q <= '0;
      ptr_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      aw_sel_q <= aw_sel_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // W-order storage: granted index written on each AW handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W_DEPTH; i++) fifo_q[i] <= '0;
    end else if (aw_hs) begin
      fifo_q[wr_q[PW-1:0]] <= aw_sel_q;
    end
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched: table vectors plus corner sequences.
// QoS sequence included when AXI_WR_SCHED_QOS_EN is defined.
module tb_axi_wr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s_awvalid;
  logic [3:0] s_awready;
  logic       m_awvalid;
  logic       m_awready;
  logic [1:0] aw_sel;
  logic [1:0] w_sel;
  logic       w_sel_valid;
  logic       w_last_hs;
  logic       b_hs;
  logic [2:0] outstanding;
  logic       err;
`ifdef AXI_WR_SCHED_QOS_EN
  logic [15:0] s_awqos;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wr_sched #(
    .S_COUNT (4),
    .ISSUE   (4),
    .W_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_awvalid   (s_awvalid),
`ifdef AXI_WR_SCHED_QOS_EN
    .s_awqos     (s_awqos),
`endif
    .s_awready   (s_awready),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .aw_sel      (aw_sel),
    .w_sel       (w_sel),
    .w_sel_valid (w_sel_valid),
    .w_last_hs   (w_last_hs),
    .b_hs        (b_hs),
    .outstanding (outstanding),
    .err         (err)
  );

  typedef struct {
    logic [3:0] av;
    logic       ar;
    logic       wl;
    logic       b;
    logic       e_mv;
    logic [1:0] e_sel;
    logic [3:0] e_rdy;
    logic [1:0] e_ws;
    logic       e_wv;
    logic [2:0] e_out;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] av,
                      input logic ar,
                      input logic wl,
                      input logic b);
    s_awvalid = av;
    m_awready = ar;
    w_last_hs = wl;
    b_hs      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    s_awvalid = '0;
    m_awready = 1'b0;
    w_last_hs = 1'b0;
    b_hs      = 1'b0;
`ifdef AXI_WR_SCHED_QOS_EN
    s_awqos   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_cnt;

    tbl[0] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 2'd0, 1'b0, 3'd0};
    tbl[1] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 1'b1, 3'd1};
    tbl[2] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 2'd0, 1'b0, 3'd0};
    tbl[3] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 1'b1, 3'd1};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4, 2'd0, 1'b0, 3'd0};
    tbl[5] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 1'b1, 3'd1};
    tbl[6] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'h8, 2'd0, 1'b0, 3'd0};
    tbl[7] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 1'b1, 3'd1};
    tbl[8] = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1, 2'd0, 1'b0, 3'd0};

    // reset values
    do_reset();
    chk("rst_mv",  32'(m_awvalid),   32'd0);
    chk("rst_rdy", 32'(s_awready),   32'd0);
    chk("rst_sel", 32'(aw_sel),      32'd0);
    chk("rst_ws",  32'(w_sel),       32'd0);
    chk("rst_wv",  32'(w_sel_valid), 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err),         32'd0);

    // fairness table
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].av, tbl[i].ar, tbl[i].wl, tbl[i].b);
      chk($sformatf("tbl%0d_mv", i), 32'(m_awvalid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv)
        chk($sformatf("tbl%0d_sel", i), 32'(aw_sel), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_rdy", i), 32'(s_awready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ws", i), 32'(w_sel), 32'(tbl[i].e_ws));
      chk($sformatf("tbl%0d_wv", i), 32'(w_sel_valid), 32'(tbl[i].e_wv));
      chk($sformatf("tbl%0d_out", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
    end

    // FIFO wrap over 10 bursts
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic p;
      p = (k >= 2) && (k % 2 == 0);
      step(4'hF, 1'b1, p, p);
      if (k % 2 == 1) begin
        chk($sformatf("wrap%0d_ws", k), 32'(w_sel), 32'(((k - 1) / 2) % 4));
        chk($sformatf("wrap%0d_wv", k), 32'(w_sel_valid), 32'd1);
      end else begin
        chk($sformatf("wrap%0d_sel", k), 32'(aw_sel), 32'((k / 2) % 4));
      end
    end
    chk("wrap_err", 32'(err), 32'd0);

    // FIFO full stall and release
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(4'hF, 1'b1, 1'b0, (k >= 2) && (k % 2 == 0));
    end
    chk("full_mv",  32'(m_awvalid),   32'd0);
    chk("full_out", 32'(outstanding), 32'd0);
    chk("full_ws",  32'(w_sel),       32'd0);
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 1'b1, 1'b0, 1'b0);
      chk("full_stall", 32'(m_awvalid), 32'd0);
    end
    step(4'hF, 1'b1, 1'b1, 1'b0);
    chk("full_pop_ws", 32'(w_sel), 32'd1);
    chk("full_pop_mv", 32'(m_awvalid), 32'd0);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    chk("full_rel_mv",  32'(m_awvalid), 32'd1);
    chk("full_rel_sel", 32'(aw_sel), 32'd0);
    chk("full_err", 32'(err), 32'd0);

    // issue cap
    do_reset();
    hs_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (m_awvalid) hs_cnt++;
      step(4'h1, 1'b1, (k >= 2) && (k % 2 == 0) && (k <= 8), 1'b0);
    end
    chk("cap_hs",  32'(hs_cnt),      32'd4);
    chk("cap_mv",  32'(m_awvalid),   32'd0);
    chk("cap_out", 32'(outstanding), 32'd4);
    step(4'h1, 1'b0, 1'b0, 1'b1);
    chk("cap_b_out", 32'(outstanding), 32'd3);
    chk("cap_b_mv",  32'(m_awvalid),   32'd0);
    step(4'h1, 1'b0, 1'b0, 1'b0);
    chk("cap_5th_mv", 32'(m_awvalid), 32'd1);
    step(4'h1, 1'b1, 1'b0, 1'b1);
    chk("cap_both_out", 32'(outstanding), 32'd3);
    chk("cap_both_mv",  32'(m_awvalid),   32'd0);
    chk("cap_err", 32'(err), 32'd0);

    // backpressure in HOLD
    do_reset();
    step(4'h4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'h4, 1'b0, 1'b0, 1'b0);
      chk("bp_mv",  32'(m_awvalid), 32'd1);
      chk("bp_sel", 32'(aw_sel),    32'd2);
      chk("bp_rdy", 32'(s_awready), 32'd0);
    end
    m_awready = 1'b1;
    #1;
    chk("bp_rdy_on", 32'(s_awready), 32'h4);
    step(4'h4, 1'b1, 1'b0, 1'b0);
    chk("bp_done_mv",  32'(m_awvalid),   32'd0);
    chk("bp_done_out", 32'(outstanding), 32'd1);

    // error: W last while FIFO empty
    do_reset();
    step(4'h0, 1'b0, 1'b1, 1'b0);
    chk("err_wl", 32'(err), 32'd1);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    chk("err_wl_sticky", 32'(err), 32'd1);
    chk("err_wl_wv", 32'(w_sel_valid), 32'd0);

    // error: B with nothing outstanding
    do_reset();
    chk("err_clr", 32'(err), 32'd0);
    step(4'h0, 1'b0, 1'b0, 1'b1);
    chk("err_b", 32'(err), 32'd1);
    chk("err_b_out", 32'(outstanding), 32'd0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    chk("err_b_sticky", 32'(err), 32'd1);

    // error: requester drops valid in HOLD
    do_reset();
    step(4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    chk("err_drop", 32'(err), 32'd1);
    chk("err_drop_mv", 32'(m_awvalid), 32'd1);

    // async reset while in HOLD
    do_reset();
    step(4'h2, 1'b1, 1'b0, 1'b0);
    step(4'h2, 1'b1, 1'b0, 1'b0);
    step(4'h2, 1'b1, 1'b0, 1'b0);
    chk("mid_pre_mv",  32'(m_awvalid),   32'd1);
    chk("mid_pre_out", 32'(outstanding), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mv",  32'(m_awvalid),   32'd0);
    chk("mid_rdy", 32'(s_awready),   32'd0);
    chk("mid_sel", 32'(aw_sel),      32'd0);
    chk("mid_out", 32'(outstanding), 32'd0);
    chk("mid_wv",  32'(w_sel_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_mv", 32'(m_awvalid), 32'd0);
    step(4'h2, 1'b1, 1'b0, 1'b0);
    chk("mid_gnt_mv",  32'(m_awvalid), 32'd1);
    chk("mid_gnt_sel", 32'(aw_sel),    32'd1);

`ifdef AXI_WR_SCHED_QOS_EN
    // QoS: high-QoS pair alternates, low-QoS only when alone
    do_reset();
    s_awqos = {4'd7, 4'd7, 4'd0, 4'd1};
    for (int k = 0; k < 8; k++) begin
      logic p;
      logic [1:0] e;
      p = (k >= 2) && (k % 2 == 0);
      step(4'hD, 1'b1, p, p);
      if (k % 2 == 0) begin
        e = ((k / 2) % 2 == 0) ? 2'd2 : 2'd3;
        chk($sformatf("qos%0d_sel", k), 32'(aw_sel), 32'(e));
      end
    end
    step(4'h1, 1'b1, 1'b1, 1'b1);
    chk("qos_alone_sel", 32'(aw_sel), 32'd0);
    chk("qos_alone_mv",  32'(m_awvalid), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
